key_expand: RTL and testbench

//  AES-128 key-schedule engine: the reader side of the rcon ROM interface. On start it

---
 rtl/key_expand_pkg.sv | 21 ++
 rtl/key_expand_sub_word.sv | 39 +++
 rtl/key_expand.sv | 158 +++++++++++++++
 tb/tb_key_expand.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_expand_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM encoding, word rotation.
package key_expand_pkg;

  localparam int NK = 4;
  localparam int NR = 10;
  localparam int NW = NK * (NR + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    GEN,
    DONE
  } state_e;

  // RotWord({a,b,c,d}) = {b,c,d,a}
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expand_sub_word.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word, purely combinational.
// Shared with the cipher datapath, so it carries no state.
module key_expand_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  // Entry 0 sits in the most significant byte, entry 255 in the least.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte x lives at bit offset 8*(255-x), and 255-x equals ~x for an 8-bit x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  // Substitute each byte independently
  always_comb begin
    word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
              sbox(word_i[15:8]),  sbox(word_i[7:0])};
  end

endmodule

// File: rtl/key_expand.sv
// AES-128 key expansion: latches a cipher key on start and writes round-key
// words w0..w43 into the round-key RAM, one word per write cycle, reading
// round constants from an external ROM with one cycle of read latency.
module key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [3:0]   rcon_addr,
  input  logic [31:0]  rcon_dout,
  output logic         rk_we,
  output logic [5:0]   rk_addr,
  output logic [31:0]  rk_data,
  output logic         busy,
  output logic         done
);
  import key_expand_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_e      state_q, state_d;
  logic [31:0] win_q [4];
  logic [31:0] win_d [4];
  logic [1:0]  k_q, k_d;
  logic [3:0]  round_q, round_d;
  logic [3:0]  rcon_addr_q, rcon_addr_d;
  logic        rk_we_q, rk_we_d;
  logic [5:0]  rk_addr_q, rk_addr_d;
  logic [31:0] rk_data_q, rk_data_d;

  logic [31:0] sub_in, sub_out, temp, new_word;

  // The next word is computed one cycle ahead of its write so that the
  // registered outputs line up with the state: the first word of a round is
  // formed during FETCH (rcon already valid there) and shows up in GEN k=0.
  assign sub_in   = rot_word(win_q[3]);
  assign temp     = (state_q == FETCH) ? (sub_out ^ rcon_dout) : win_q[3];
  assign new_word = win_q[0] ^ temp;

  key_expand_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // Next-state, window and output-register logic
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    k_d         = k_q;
    round_d     = round_q;
    rcon_addr_d = rcon_addr_q;
    rk_we_d     = 1'b0;
    rk_addr_d   = rk_addr_q;
    rk_data_d   = rk_data_q;
    unique case (state_q)
      IDLE, DONE: begin
        // DONE also accepts start so a held start chains runs with a single
        // DONE cycle between them.
        if (start) begin
          state_d     = LOAD;
          win_d[0]    = key_in[127:96];
          win_d[1]    = key_in[95:64];
          win_d[2]    = key_in[63:32];
          win_d[3]    = key_in[31:0];
          k_d         = 2'd0;
          round_d     = 4'd1;
          // Round 1 constant is requested early so it is valid by FETCH.
          rcon_addr_d = 4'd1;
          rk_we_d     = 1'b1;
          rk_addr_d   = 6'd0;
          rk_data_d   = key_in[127:96];
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (k_q != 2'd3) begin
          k_d       = k_q + 2'd1;
          rk_we_d   = 1'b1;
          rk_addr_d = rk_addr_q + 6'd1;
          rk_data_d = win_q[k_q + 2'd1];
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d   = GEN;
        k_d       = 2'd0;
        rk_we_d   = 1'b1;
        rk_addr_d = rk_addr_q + 6'd1;
        rk_data_d = new_word;
        win_d[0]  = win_q[1];
        win_d[1]  = win_q[2];
        win_d[2]  = win_q[3];
        win_d[3]  = new_word;
      end
      GEN: begin
        if (k_q != 2'd3) begin
          k_d       = k_q + 2'd1;
          rk_we_d   = 1'b1;
          rk_addr_d = rk_addr_q + 6'd1;
          rk_data_d = new_word;
          win_d[0]  = win_q[1];
          win_d[1]  = win_q[2];
          win_d[2]  = win_q[3];
          win_d[3]  = new_word;
          // Advance the ROM address in the last GEN cycle so the next
          // constant arrives during the following FETCH.
          if (k_q == 2'd2 && round_q != LAST_ROUND) begin
            rcon_addr_d = round_q + 4'd1;
          end
        end else if (round_q != LAST_ROUND) begin
          state_d = FETCH;
          round_d = round_q + 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      round_q     <= 4'd0;
      rcon_addr_q <= 4'd0;
      rk_we_q     <= 1'b0;
      rk_addr_q   <= 6'd0;
      rk_data_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      round_q     <= round_d;
      rcon_addr_q <= rcon_addr_d;
      rk_we_q     <= rk_we_d;
      rk_addr_q   <= rk_addr_d;
      rk_data_q   <= rk_data_d;
    end
  end

  // Key window is pure data; it is always reloaded on start before use
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign rcon_addr = rcon_addr_q;
  assign rk_we     = rk_we_q;
  assign rk_addr   = rk_addr_q;
  assign rk_data   = rk_data_q;
  assign busy      = (state_q == LOAD) || (state_q == FETCH) || (state_q == GEN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_key_expand.sv
`timescale 1ns/1ps
module tb_key_expand;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam int MAXC = 130;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rcon_addr;
  logic [31:0]  rcon_dout;
  logic         rk_we;
  logic [5:0]   rk_addr;
  logic [31:0]  rk_data;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_expand #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .rcon_addr (rcon_addr),
    .rcon_dout (rcon_dout),
    .rk_we     (rk_we),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .busy      (busy),
    .done      (done)
  );

  // Registered rcon ROM, one cycle read latency
  always_ff @(posedge clk) begin
    case (rcon_addr)
      4'd1:    rcon_dout <= 32'h01000000;
      4'd2:    rcon_dout <= 32'h02000000;
      4'd3:    rcon_dout <= 32'h04000000;
      4'd4:    rcon_dout <= 32'h08000000;
      4'd5:    rcon_dout <= 32'h10000000;
      4'd6:    rcon_dout <= 32'h20000000;
      4'd7:    rcon_dout <= 32'h40000000;
      4'd8:    rcon_dout <= 32'h80000000;
      4'd9:    rcon_dout <= 32'h1b000000;
      4'd10:   rcon_dout <= 32'h36000000;
      default: rcon_dout <= 32'h00000000;
    endcase
  end

  // ---------------- reference model (S-box computed from GF(2^8)) ----------
  logic [7:0]  sbox_m [256];
  logic [31:0] exp_w [44];
  logic [31:0] exp_b [44];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] base;
    logic [7:0] s;
    logic [7:0] r;
    inv  = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    s = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  task automatic init_sbox();
    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) exp_w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = exp_w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      exp_w[i] = exp_w[i-4] ^ t;
    end
  endtask

  // ---------------- run driver / recorder ----------------------------------
  logic         pl_start [1:MAXC];
  logic [127:0] pl_key   [1:MAXC];
  int           nwr, ndone, nbusy, first_done, second_done, nfetch, nviol;
  logic [5:0]   wr_addr [0:127];
  logic [31:0]  wr_data [0:127];
  int           wr_cyc  [0:127];
  logic [3:0]   fetch_rc [0:31];

  task automatic clear_plan(input logic [127:0] key);
    for (int c = 1; c <= MAXC; c++) begin
      pl_start[c] = 1'b0;
      pl_key[c]   = key;
    end
  endtask

  // Cycle 1 is the first cycle after the edge that samples start.
  task automatic run(input logic [127:0] key, input int ncyc);
    nwr = 0; ndone = 0; nbusy = 0; first_done = -1; second_done = -1;
    nfetch = 0; nviol = 0;
    for (int i = 0; i < 128; i++) begin
      wr_addr[i] = 'x; wr_data[i] = 'x; wr_cyc[i] = -1;
    end
    @(negedge clk);
    start  = 1'b1;
    key_in = key;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      #1;
      if (rk_we === 1'b1) begin
        if (nwr < 128) begin
          wr_addr[nwr] = rk_addr; wr_data[nwr] = rk_data; wr_cyc[nwr] = c;
        end
        nwr++;
      end
      if (done === 1'b1) begin
        if (ndone == 0) first_done = c;
        else if (ndone == 1) second_done = c;
        ndone++;
      end
      if (busy === 1'b1) begin
        nbusy++;
        if (rcon_addr < 4'd1 || rcon_addr > 4'd10 || rk_addr > 6'd43) nviol++;
        if (rk_we !== 1'b1) begin
          if (nfetch < 32) fetch_rc[nfetch] = rcon_addr;
          nfetch++;
        end
      end
      start  = pl_start[c];
      key_in = pl_key[c];
      @(posedge clk);
    end
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rk_we !== 1'b0)      begin n_err++; $display("FAIL reset_rk_we got %b want 0", rk_we); end
    n_cmp++; if (rk_addr !== 6'd0)    begin n_err++; $display("FAIL reset_rk_addr got %0d want 0", rk_addr); end
    n_cmp++; if (rk_data !== 32'd0)   begin n_err++; $display("FAIL reset_rk_data got %h want 0", rk_data); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (rcon_addr !== 4'd0)  begin n_err++; $display("FAIL reset_rcon_addr got %0d want 0", rcon_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_fips();
    build_model(KEY_FIPS);
    clear_plan(KEY_FIPS);
    run(KEY_FIPS, 60);
    n_cmp++; if (nwr != 44) begin n_err++; $display("FAIL fips_write_count got %0d want 44", nwr); end
    for (int i = 0; i < 44; i++) begin
      n_cmp++;
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== exp_w[i]) begin
        n_err++;
        $display("FAIL fips_w%0d got addr %0d data %h want addr %0d data %h", i, wr_addr[i], wr_data[i], i, exp_w[i]);
      end
    end
    n_cmp++; if (wr_data[4]  !== 32'ha0fafe17) begin n_err++; $display("FAIL fips_w4 got %h want a0fafe17", wr_data[4]); end
    n_cmp++; if (wr_data[40] !== 32'hd014f9a8) begin n_err++; $display("FAIL fips_w40 got %h want d014f9a8", wr_data[40]); end
    n_cmp++; if (wr_data[43] !== 32'hb6630ca6) begin n_err++; $display("FAIL fips_w43 got %h want b6630ca6", wr_data[43]); end
    n_cmp++; if (first_done != 55) begin n_err++; $display("FAIL fips_done_cycle got %0d want 55", first_done); end
    n_cmp++; if (ndone != 1)  begin n_err++; $display("FAIL fips_done_pulses got %0d want 1", ndone); end
    n_cmp++; if (nbusy != 54) begin n_err++; $display("FAIL fips_busy_cycles got %0d want 54", nbusy); end
    n_cmp++; if (wr_cyc[0] != 1 || wr_cyc[43] != 54) begin
      n_err++; $display("FAIL fips_write_window got %0d..%0d want 1..54", wr_cyc[0], wr_cyc[43]);
    end
  endtask

  task automatic test_zero_key();
    build_model(128'h0);
    clear_plan(128'h0);
    run(128'h0, 60);
    n_cmp++; if (wr_data[4]  !== 32'h62636363) begin n_err++; $display("FAIL zero_w4 got %h want 62636363", wr_data[4]); end
    n_cmp++; if (wr_data[43] !== 32'h6f8f188e) begin n_err++; $display("FAIL zero_w43 got %h want 6f8f188e", wr_data[43]); end
    for (int i = 0; i < 44; i++) begin
      n_cmp++;
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== exp_w[i]) begin
        n_err++;
        $display("FAIL zero_w%0d got addr %0d data %h want addr %0d data %h", i, wr_addr[i], wr_data[i], i, exp_w[i]);
      end
    end
    n_cmp++; if (nfetch != 10) begin n_err++; $display("FAIL zero_fetch_count got %0d want 10", nfetch); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (fetch_rc[i] !== 4'(i + 1)) begin
        n_err++; $display("FAIL zero_fetch_rcon%0d got %0d want %0d", i, fetch_rc[i], i + 1);
      end
    end
    n_cmp++; if (nviol != 0) begin n_err++; $display("FAIL zero_busy_ranges got %0d bad cycles want 0", nviol); end
  endtask

  task automatic test_ignore_start();
    build_model(KEY_FIPS);
    clear_plan(KEY_FIPS);
    for (int c = 5; c <= MAXC; c++) pl_key[c] = KEY_ALT;
    pl_start[10] = 1'b1;
    pl_start[54] = 1'b1;
    run(KEY_FIPS, 70);
    n_cmp++; if (nwr != 44) begin n_err++; $display("FAIL ignore_write_count got %0d want 44", nwr); end
    for (int i = 0; i < 44; i++) begin
      n_cmp++;
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== exp_w[i]) begin
        n_err++;
        $display("FAIL ignore_w%0d got addr %0d data %h want addr %0d data %h", i, wr_addr[i], wr_data[i], i, exp_w[i]);
      end
    end
    n_cmp++; if (first_done != 55 || ndone != 1) begin
      n_err++; $display("FAIL ignore_done got cycle %0d pulses %0d want cycle 55 pulses 1", first_done, ndone);
    end
  endtask

  task automatic test_reset_midrun();
    int cnt_we;
    int cnt_done;
    build_model(KEY_FIPS);
    clear_plan(KEY_FIPS);
    @(negedge clk);
    start  = 1'b1;
    key_in = KEY_FIPS;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rk_we !== 1'b0)   begin n_err++; $display("FAIL midrst_rk_we got %b want 0", rk_we); end
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (rk_addr !== 6'd0) begin n_err++; $display("FAIL midrst_rk_addr got %0d want 0", rk_addr); end
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL midrst_done got %b want 0", done); end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt_we = 0;
    cnt_done = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (rk_we === 1'b1) cnt_we++;
      if (done === 1'b1) cnt_done++;
    end
    n_cmp++; if (cnt_we != 0 || cnt_done != 0) begin
      n_err++; $display("FAIL midrst_idle got writes %0d done %0d want 0 0", cnt_we, cnt_done);
    end
    run(KEY_FIPS, 60);
    n_cmp++; if (nwr != 44) begin n_err++; $display("FAIL midrst_restart_count got %0d want 44", nwr); end
    for (int i = 0; i < 44; i++) begin
      n_cmp++;
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== exp_w[i]) begin
        n_err++;
        $display("FAIL midrst_w%0d got addr %0d data %h want addr %0d data %h", i, wr_addr[i], wr_data[i], i, exp_w[i]);
      end
    end
    n_cmp++; if (first_done != 55) begin n_err++; $display("FAIL midrst_done_cycle got %0d want 55", first_done); end
  endtask

  task automatic test_back_to_back();
    build_model(KEY_ALT);
    exp_b = exp_w;
    build_model(KEY_FIPS);
    clear_plan(KEY_FIPS);
    for (int c = 1; c <= 100; c++) pl_start[c] = 1'b1;
    for (int c = 3; c <= MAXC; c++) pl_key[c] = KEY_ALT;
    run(KEY_FIPS, 115);
    n_cmp++; if (nwr != 88) begin n_err++; $display("FAIL b2b_write_count got %0d want 88", nwr); end
    for (int i = 0; i < 88; i++) begin
      n_cmp++;
      if (wr_addr[i] !== 6'(i % 44) || wr_data[i] !== ((i < 44) ? exp_w[i] : exp_b[i-44])) begin
        n_err++;
        $display("FAIL b2b_write%0d got addr %0d data %h want addr %0d data %h", i, wr_addr[i], wr_data[i],
                 i % 44, (i < 44) ? exp_w[i] : exp_b[i-44]);
      end
    end
    n_cmp++; if (first_done != 55 || second_done != 110 || ndone != 2) begin
      n_err++; $display("FAIL b2b_done got %0d,%0d (%0d pulses) want 55,110 (2)", first_done, second_done, ndone);
    end
    n_cmp++; if (wr_cyc[44] != 56) begin n_err++; $display("FAIL b2b_second_start got cycle %0d want 56", wr_cyc[44]); end
    n_cmp++; if (nbusy != 108) begin n_err++; $display("FAIL b2b_busy_cycles got %0d want 108", nbusy); end
  endtask

  task automatic test_random();
    logic [127:0] key;
    int bad;
    for (int r = 0; r < 100; r++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      build_model(key);
      clear_plan(key);
      run(key, 57);
      bad = 0;
      for (int i = 0; i < 44; i++) begin
        if (wr_addr[i] !== 6'(i) || wr_data[i] !== exp_w[i]) bad++;
      end
      n_cmp++;
      if (bad != 0 || nwr != 44 || first_done != 55) begin
        n_err++;
        $display("FAIL rand%0d key %h got bad_words %0d writes %0d done %0d want 0 44 55",
                 r, key, bad, nwr, first_done);
      end
      n_cmp++;
      if (nviol != 0) begin
        n_err++; $display("FAIL rand%0d_busy_ranges got %0d bad cycles want 0", r, nviol);
      end
    end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
